// File: rtl/bus_arbiter.sv
// bus_arbiter: main-bus arbiter for the cache requesters
// (0 = dcache writeback, 1 = dcache fill, 2 = icache fill by default).
// Round-robin grant with a one-cycle turnaround between owners and a grant
// timeout that revokes a grant the owner never uses.
// Optional feature macro: BUS_ARB_WB_PRIORITY_EN -- requester 0 (writeback)
// wins outright whenever it requests; the others round-robin among themselves.
// Valid configurations: N_REQ 2..8, GRANT_TIMEOUT 1..255.
module bus_arbiter #(
   parameter int unsigned N_REQ         = 3,
   parameter int unsigned GRANT_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] reqcyc,
   input  logic [N_REQ-1:0] busy,
   output logic [N_REQ-1:0] grant,
   output logic [2:0]       owner,
   output logic             bus_idle,
   output logic             timeout_pulse
);

   typedef enum logic [1:0] {StIdle, StGrant, StHold, StTurn} state_e;

`ifdef BUS_ARB_WB_PRIORITY_EN
   // Requester 0 never takes part in the rotation, so the pointer starts at 1.
   localparam logic [2:0] RrReset = 3'd1;
`else
   localparam logic [2:0] RrReset = 3'd0;
`endif

   state_e     state;
   logic [2:0] rr_ptr;
   logic [7:0] timer;

   logic       win_valid;
   logic [2:0] win_idx;
   logic [3:0] sum;
   logic [2:0] next_ptr;
   logic [3:0] ptr_inc;
   logic       own_busy;
   logic       own_req;
   logic       timer_expire;

`ifdef BUS_ARB_WB_PRIORITY_EN
   localparam int unsigned NRest = N_REQ - 1;

   logic [NRest-1:0] rot;
   logic [2:0]       base;

   // Winner select: requester 0 first, then rotate over 1..N_REQ-1 from rr_ptr.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      sum       = '0;
      base      = rr_ptr - 3'd1;
      rot       = NRest'({reqcyc[N_REQ-1:1], reqcyc[N_REQ-1:1]} >> base);
      // Descending so the lowest rotated offset is the last (winning) write.
      for (int i = int'(NRest) - 1; i >= 0; i--) begin
         if (rot[i]) begin
            win_valid = 1'b1;
            sum       = {1'b0, base} + 4'(i);
            if (sum >= 4'(NRest)) begin
               sum = sum - 4'(NRest);
            end
            win_idx = sum[2:0] + 3'd1;
         end
      end
      if (reqcyc[0]) begin
         win_valid = 1'b1;
         win_idx   = '0;
      end
   end
`else
   logic [N_REQ-1:0] rot;

   // Winner select: first requester at or after rr_ptr, wrapping modulo N_REQ.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      sum       = '0;
      rot       = N_REQ'({reqcyc, reqcyc} >> rr_ptr);
      // Descending so the lowest rotated offset is the last (winning) write.
      for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
         if (rot[i]) begin
            win_valid = 1'b1;
            sum       = {1'b0, rr_ptr} + 4'(i);
            if (sum >= 4'(N_REQ)) begin
               sum = sum - 4'(N_REQ);
            end
            win_idx = sum[2:0];
         end
      end
   end
`endif

   // Pointer for the next arbitration: one past the current owner.
   always_comb begin
      ptr_inc = {1'b0, owner} + 4'd1;
      if (ptr_inc >= 4'(N_REQ)) begin
         ptr_inc = {1'b0, RrReset};
      end
      next_ptr = ptr_inc[2:0];
   end

   // grant is one-hot on the owner while GRANT/HOLD, so masking picks the owner's lines.
   assign own_busy     = |(busy & grant);
   assign own_req      = |(reqcyc & grant);
   assign timer_expire = ({1'b0, timer} + 9'd1) >= 9'(GRANT_TIMEOUT);

   // Arbiter FSM; every output is a register updated alongside the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= StIdle;
         grant         <= '0;
         owner         <= '0;
         bus_idle      <= 1'b1;
         timeout_pulse <= 1'b0;
         rr_ptr        <= RrReset;
         timer         <= '0;
      end else begin
         timeout_pulse <= 1'b0;
         unique case (state)
            StIdle: begin
               if (win_valid) begin
                  state    <= StGrant;
                  grant    <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                  owner    <= win_idx;
                  bus_idle <= 1'b0;
                  timer    <= '0;
               end
            end
            StGrant: begin
               // Owner taking the bus beats a simultaneous timeout.
               if (own_busy) begin
                  state <= StHold;
               end else if (!own_req) begin
                  state  <= StTurn;
                  grant  <= '0;
                  owner  <= '0;
                  rr_ptr <= next_ptr;
               end else if (timer_expire) begin
                  state         <= StTurn;
                  grant         <= '0;
                  owner         <= '0;
                  rr_ptr        <= next_ptr;
                  timeout_pulse <= 1'b1;
                  timer         <= 8'(GRANT_TIMEOUT);
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            StHold: begin
               if (!own_busy) begin
                  state  <= StTurn;
                  grant  <= '0;
                  owner  <= '0;
                  rr_ptr <= next_ptr;
               end
            end
            StTurn: begin
               state    <= StIdle;
               bus_idle <= 1'b1;
            end
            default: begin
               state    <= StIdle;
               grant    <= '0;
               owner    <= '0;
               bus_idle <= 1'b1;
            end
         endcase
      end
   end

   // Structural invariants of the grant outputs.
   a_grant_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
   a_owner_zero : assert property (@(posedge clk) disable iff (reset)
      (grant == '0) |-> (owner == 3'd0));
   a_idle_state : assert property (@(posedge clk) disable iff (reset)
      bus_idle == (state == StIdle));
   a_no_owner_swap : assert property (@(posedge clk) disable iff (reset)
      (grant != '0) |=> (grant == '0) || (grant == $past(grant)));
   a_pulse_in_turn : assert property (@(posedge clk) disable iff (reset)
      timeout_pulse |-> (grant == '0) && !bus_idle);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scenario-driven bench for bus_arbiter (N_REQ=3, GRANT_TIMEOUT=15).
// Expected grants are queued when a request is raised and compared when the
// grant appears.  Follows BUS_ARB_WB_PRIORITY_EN if it is defined for the build.
module tb_bus_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] reqcyc;
   logic [2:0] busy;
   logic [2:0] grant;
   logic [2:0] owner;
   logic       bus_idle;
   logic       timeout_pulse;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [2:0] g;
      logic [2:0] o;
   } exp_t;

   exp_t sb[$];

   bus_arbiter #(
      .N_REQ         (3),
      .GRANT_TIMEOUT (15)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .reqcyc        (reqcyc),
      .busy          (busy),
      .grant         (grant),
      .owner         (owner),
      .bus_idle      (bus_idle),
      .timeout_pulse (timeout_pulse)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      reqcyc = '0;
      busy   = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   // Bounded wait for any grant; caller judges the outcome.
   task automatic wait_grant(input int budget, output bit seen);
      seen = (grant != '0);
      for (int i = 0; i < budget && !seen; i++) begin
         step();
         seen = (grant != '0);
      end
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      reqcyc = 3'b111;
      busy   = 3'b111;
      step();
      step();
      n_checks++;
      if (grant !== 3'b000) begin
         n_fail++; $display("FAIL reset_grant: got %b want 000", grant);
      end
      n_checks++;
      if (owner !== 3'd0) begin
         n_fail++; $display("FAIL reset_owner: got %0d want 0", owner);
      end
      n_checks++;
      if (bus_idle !== 1'b1) begin
         n_fail++; $display("FAIL reset_bus_idle: got %b want 1", bus_idle);
      end
      n_checks++;
      if (timeout_pulse !== 1'b0) begin
         n_fail++; $display("FAIL reset_timeout_pulse: got %b want 0", timeout_pulse);
      end
      reqcyc = '0;
      busy   = '0;
      reset  = 1'b0;
      step();
   endtask

   task automatic test_single_hold();
      exp_t e;
      bit   seen;
      do_reset();
      reqcyc = 3'b010;
      sb.push_back('{g: 3'b010, o: 3'd1});
      wait_grant(1, seen);
      n_checks++;
      if (!seen || sb.size() == 0) begin
         n_fail++; $display("FAIL hold_first_grant: got %b want 010 after one edge", grant);
         sb.delete();
      end else begin
         e = sb.pop_front();
         n_checks++;
         if (grant !== e.g || owner !== e.o) begin
            n_fail++;
            $display("FAIL hold_grant_sb: got %b/%0d want %b/%0d", grant, owner, e.g, e.o);
         end
      end
      busy   = 3'b010;
      reqcyc = 3'b000;
      for (int k = 0; k < 8; k++) begin
         step();
         n_checks++;
         if (grant !== 3'b010) begin
            n_fail++; $display("FAIL hold_keep_%0d: got %b want 010", k, grant);
         end
      end
      busy = 3'b000;
      step();
      n_checks++;
      if (grant !== 3'b000 || owner !== 3'd0 || bus_idle !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_turn: got %b/%0d/%b want 000/0/0", grant, owner, bus_idle);
      end
      step();
      n_checks++;
      if (bus_idle !== 1'b1 || grant !== 3'b000) begin
         n_fail++; $display("FAIL hold_idle: got idle %b grant %b want 1/000", bus_idle, grant);
      end
   endtask

   task automatic test_round_robin();
      exp_t e;
      bit   seen;
      do_reset();
      reqcyc = 3'b111;
`ifdef BUS_ARB_WB_PRIORITY_EN
      for (int r = 0; r < 4; r++) sb.push_back('{g: 3'b001, o: 3'd0});
`else
      sb.push_back('{g: 3'b001, o: 3'd0});
      sb.push_back('{g: 3'b010, o: 3'd1});
      sb.push_back('{g: 3'b100, o: 3'd2});
      sb.push_back('{g: 3'b001, o: 3'd0});
`endif
      for (int r = 0; r < 4; r++) begin
         wait_grant(4, seen);
         e = '0;
         n_checks++;
         if (!seen || sb.size() == 0) begin
            n_fail++; $display("FAIL rr_grant_seen_%0d: got %b want a grant", r, grant);
         end else begin
            e = sb.pop_front();
            n_checks++;
            if (grant !== e.g || owner !== e.o) begin
               n_fail++;
               $display("FAIL rr_order_%0d: got %b/%0d want %b/%0d", r, grant, owner, e.g, e.o);
            end
         end
         busy = e.g;
         for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if (grant !== e.g) begin
               n_fail++; $display("FAIL rr_hold_%0d_%0d: got %b want %b", r, k, grant, e.g);
            end
         end
         busy = 3'b000;
         step();
         n_checks++;
         if (grant !== 3'b000) begin
            n_fail++; $display("FAIL rr_turn_%0d: got %b want 000", r, grant);
         end
      end
      reqcyc = 3'b000;
      step();
      step();
   endtask

   task automatic test_timeout();
      exp_t e;
      bit   seen;
      bit   early;
      int   cnt;
      do_reset();
      reqcyc = 3'b100;
      sb.push_back('{g: 3'b100, o: 3'd2});
      wait_grant(2, seen);
      n_checks++;
      if (!seen || sb.size() == 0) begin
         n_fail++; $display("FAIL to_grant_seen: got %b want 100", grant);
         sb.delete();
      end else begin
         e = sb.pop_front();
         n_checks++;
         if (grant !== e.g || owner !== e.o) begin
            n_fail++;
            $display("FAIL to_grant_sb: got %b/%0d want %b/%0d", grant, owner, e.g, e.o);
         end
      end
      cnt   = 0;
      early = 1'b0;
      while (grant == 3'b100 && cnt < 40) begin
         cnt++;
         if (timeout_pulse) early = 1'b1;
         step();
      end
      n_checks++;
      if (cnt != 15) begin
         n_fail++; $display("FAIL to_grant_cycles: got %0d want 15", cnt);
      end
      n_checks++;
      if (early) begin
         n_fail++; $display("FAIL to_pulse_early: got pulse during grant want none");
      end
      n_checks++;
      if (grant !== 3'b000 || timeout_pulse !== 1'b1 || bus_idle !== 1'b0) begin
         n_fail++;
         $display("FAIL to_revoke: got grant %b pulse %b idle %b want 000/1/0",
                  grant, timeout_pulse, bus_idle);
      end
      reqcyc = 3'b000;
      step();
      n_checks++;
      if (timeout_pulse !== 1'b0 || grant !== 3'b000 || bus_idle !== 1'b1) begin
         n_fail++;
         $display("FAIL to_after: got pulse %b grant %b idle %b want 0/000/1",
                  timeout_pulse, grant, bus_idle);
      end
   endtask

   task automatic test_busy_at_expiry();
      exp_t e;
      bit   seen;
      do_reset();
      reqcyc = 3'b100;
      sb.push_back('{g: 3'b100, o: 3'd2});
      wait_grant(2, seen);
      n_checks++;
      if (!seen || sb.size() == 0) begin
         n_fail++; $display("FAIL exp_grant_seen: got %b want 100", grant);
         sb.delete();
      end else begin
         e = sb.pop_front();
         n_checks++;
         if (grant !== e.g || owner !== e.o) begin
            n_fail++;
            $display("FAIL exp_grant_sb: got %b/%0d want %b/%0d", grant, owner, e.g, e.o);
         end
      end
      // Fifteenth grant cycle: busy rises on the very edge the timer expires.
      for (int k = 0; k < 14; k++) step();
      busy = 3'b100;
      step();
      n_checks++;
      if (grant !== 3'b100 || timeout_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL exp_hold_wins: got grant %b pulse %b want 100/0", grant, timeout_pulse);
      end
      step();
      n_checks++;
      if (grant !== 3'b100 || timeout_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL exp_hold_no_timeout: got grant %b pulse %b want 100/0",
                  grant, timeout_pulse);
      end
      busy   = 3'b000;
      reqcyc = 3'b000;
      step();
      n_checks++;
      if (grant !== 3'b000 || timeout_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL exp_release: got grant %b pulse %b want 000/0", grant, timeout_pulse);
      end
      step();
   endtask

   task automatic test_rr_pointer();
      exp_t e;
      bit   seen;
      do_reset();
      reqcyc = 3'b001;
      sb.push_back('{g: 3'b001, o: 3'd0});
      wait_grant(2, seen);
      n_checks++;
      if (!seen || sb.size() == 0) begin
         n_fail++; $display("FAIL ptr_first_seen: got %b want 001", grant);
         sb.delete();
      end else begin
         e = sb.pop_front();
         n_checks++;
         if (grant !== e.g || owner !== e.o) begin
            n_fail++;
            $display("FAIL ptr_first_sb: got %b/%0d want %b/%0d", grant, owner, e.g, e.o);
         end
      end
      // Withdraw the request: straight to TURN with no timeout pulse.
      reqcyc = 3'b000;
      step();
      n_checks++;
      if (grant !== 3'b000 || timeout_pulse !== 1'b0 || bus_idle !== 1'b0) begin
         n_fail++;
         $display("FAIL ptr_withdraw: got grant %b pulse %b idle %b want 000/0/0",
                  grant, timeout_pulse, bus_idle);
      end
      // Everyone requests during TURN; the following IDLE arbitrates with rr_ptr=1.
      reqcyc = 3'b111;
`ifdef BUS_ARB_WB_PRIORITY_EN
      sb.push_back('{g: 3'b001, o: 3'd0});
`else
      sb.push_back('{g: 3'b010, o: 3'd1});
`endif
      step();
      n_checks++;
      if (bus_idle !== 1'b1 || grant !== 3'b000) begin
         n_fail++; $display("FAIL ptr_idle: got idle %b grant %b want 1/000", bus_idle, grant);
      end
      step();
      n_checks++;
      if (sb.size() == 0) begin
         n_fail++; $display("FAIL ptr_second_sb: got empty queue want one entry");
      end else begin
         e = sb.pop_front();
         if (grant !== e.g || owner !== e.o) begin
            n_fail++;
            $display("FAIL ptr_second: got %b/%0d want %b/%0d", grant, owner, e.g, e.o);
         end
      end
      reqcyc = 3'b000;
      step();
      step();
   endtask

   task automatic test_reset_in_hold();
      exp_t e;
      bit   seen;
      do_reset();
      reqcyc = 3'b010;
      sb.push_back('{g: 3'b010, o: 3'd1});
      wait_grant(2, seen);
      n_checks++;
      if (!seen || sb.size() == 0) begin
         n_fail++; $display("FAIL rh_grant_seen: got %b want 010", grant);
         sb.delete();
      end else begin
         e = sb.pop_front();
         n_checks++;
         if (grant !== e.g || owner !== e.o) begin
            n_fail++;
            $display("FAIL rh_grant_sb: got %b/%0d want %b/%0d", grant, owner, e.g, e.o);
         end
      end
      busy = 3'b010;
      step();
      // Non-owner activity while holding must not disturb the grant.
      busy   = 3'b111;
      reqcyc = 3'b101;
      step();
      n_checks++;
      if (grant !== 3'b010 || owner !== 3'd1) begin
         n_fail++; $display("FAIL rh_nonowner: got %b/%0d want 010/1", grant, owner);
      end
      reset = 1'b1;
      step();
      n_checks++;
      if (grant !== 3'b000 || owner !== 3'd0 || bus_idle !== 1'b1 || timeout_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL rh_reset: got %b/%0d idle %b pulse %b want 000/0/1/0",
                  grant, owner, bus_idle, timeout_pulse);
      end
      reset  = 1'b0;
      busy   = 3'b000;
      reqcyc = 3'b000;
      step();
      n_checks++;
      if (grant !== 3'b000 || bus_idle !== 1'b1) begin
         n_fail++; $display("FAIL rh_after: got grant %b idle %b want 000/1", grant, bus_idle);
      end
   endtask

   initial begin
      reset  = 1'b1;
      reqcyc = '0;
      busy   = '0;
      test_reset();
      test_single_hold();
      test_round_robin();
      test_timeout();
      test_busy_at_expiry();
      test_rr_pointer();
      test_reset_in_hold();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter N_REQ, default 3, number of requesters (0 = dcache writeback, 1 = dcache fill, 2 = icache fill); SHALL be 2..8.
REQ-002 Parameter GRANT_TIMEOUT, default 15, cycles a grant SHALL wait for busy before revocation; SHALL be 1..255.
REQ-003 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 reqcyc  input  N_REQ  per-requester bus request (abtr_reqcyc of each requester).
REQ-006 busy  input  N_REQ  per-requester bus_busy, high while that requester drives the main bus.
REQ-007 grant  output  N_REQ  one-hot or zero grant (abtr_grant of each requester).
REQ-008 owner  output  3  index of current grantee; SHALL be 0 when grant is zero.
REQ-009 bus_idle  output  1  high only in state IDLE.
REQ-010 timeout_pulse  output  1  one-cycle pulse on grant revocation by timeout.

Function
REQ-011 States IDLE, GRANT, HOLD, TURN; all outputs SHALL be registered.
REQ-012 IDLE: any reqcyc bit high SHALL select a winner, register it, enter GRANT; grant[winner] high in the next cycle (1-cycle latency).
REQ-013 Default arbitration SHALL be round-robin: search starts at rr_ptr and wraps modulo N_REQ; the first requester with reqcyc high wins.
REQ-014 GRANT: grant[owner] SHALL stay high; busy[owner] high -> HOLD; reqcyc[owner] low with busy low -> TURN (withdrawn request); timer reaching GRANT_TIMEOUT -> TURN with timeout_pulse high for one cycle.
REQ-015 Timer SHALL clear on entry to GRANT and increment once per cycle in GRANT only; it SHALL NOT wrap.
REQ-016 HOLD: grant[owner] SHALL stay high while busy[owner] is high; busy[owner] falling -> TURN. The timeout SHALL NOT apply in HOLD.
REQ-017 TURN: grant SHALL be zero for exactly one cycle; rr_ptr SHALL become (owner+1) mod N_REQ; next state IDLE.
REQ-018 At most one grant bit SHALL be high in any cycle; grant SHALL never change owner without passing through TURN.
REQ-019 busy or reqcyc changes on non-owner requesters SHALL be ignored outside IDLE.
REQ-020 Simultaneous busy[owner] rise and timer expiry in GRANT: HOLD SHALL take precedence; no timeout_pulse.
REQ-021 Request and release on the same edge (requester re-raises reqcyc during TURN) SHALL be arbitrated in the following IDLE cycle with the updated rr_ptr.

Reset
REQ-022 On reset: state IDLE, grant 0, owner 0, bus_idle 1, timeout_pulse 0, rr_ptr 0, timer 0.
REQ-023 Reset asserted in any state SHALL take effect at the next posedge regardless of busy, abandoning any in-flight grant.

Configuration
REQ-024 Macro BUS_ARB_WB_PRIORITY_EN: when defined, requester 0 SHALL win in IDLE whenever reqcyc[0] is high, with the remaining requesters round-robin among themselves, and rr_ptr never pointing at 0.
REQ-025 Without BUS_ARB_WB_PRIORITY_EN, pure round-robin per REQ-013 across all N_REQ requesters.

Verification
REQ-026 After reset, reqcyc=3'b010 at cycle 0 -> grant=3'b010 at cycle 1, owner=1; busy[1] high cycles 2-9 -> grant held through cycle 9, zero at cycle 10 (TURN), bus_idle=1 at cycle 11.
REQ-027 reqcyc=3'b111 held continuously, each owner busy 4 cycles -> grant order 0,1,2,0 with one zero-grant cycle between owners.
REQ-028 reqcyc=3'b100, busy never asserted -> grant[2] high 15 cycles, timeout_pulse one cycle, then grant zero one cycle, then IDLE.
REQ-029 BUS_ARB_WB_PRIORITY_EN defined, rr_ptr=1, reqcyc=3'b111 -> requester 0 granted first; without the macro -> requester 1 granted first.
REQ-030 Reset asserted during HOLD with busy[1] still high -> grant=0, owner=0, bus_idle=1 at the next posedge.
